// File: rtl/conv_seq_ctrl_pkg.sv
// conv_pkg: shared types and constants for the convolution sequencer slice.
//   conv_state_t : sequencer FSM encoding (LOAD, MAC, DRAIN, OUT)
//   MEM_RD_LAT   : read latency of the external F/X memories, in cycles
//   PERF_CNT_W   : width of the optional stall counter (CONV_SEQ_PERF_EN)
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } conv_state_t;

    localparam int unsigned MEM_RD_LAT = 1;
    localparam int unsigned PERF_CNT_W = 16;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if: bundles the sequencer's stream handshakes, memory
// write/read addressing, MAC controls and status into one interface.
//   master : the sequencer side (drives s_ready_x, strobes, addresses,
//            mac_clr/mac_en, m_valid_y, conv_busy[, stall_cnt])
//   slave  : the surrounding datapath (drives s_valid_x, m_ready_y)
// Optional: CONV_SEQ_PERF_EN adds stall_cnt.
interface conv_seq_ctrl_if
    import conv_pkg::*;
#(
    parameter int unsigned X_MEM_ADDR_WIDTH = 3,
    parameter int unsigned F_MEM_ADDR_WIDTH = 2
);
    logic                        s_valid_x;
    logic                        s_ready_x;
    logic                        f_wr_en;
    logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr;
    logic                        x_wr_en;
    logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr;
    logic [F_MEM_ADDR_WIDTH-1:0] f_rd_addr;
    logic [X_MEM_ADDR_WIDTH-1:0] x_rd_addr;
    logic                        mac_clr;
    logic                        mac_en;
    logic                        m_valid_y;
    logic                        m_ready_y;
    logic                        conv_busy;
`ifdef CONV_SEQ_PERF_EN
    logic [PERF_CNT_W-1:0]       stall_cnt;
`endif

    modport master (
        input  s_valid_x, m_ready_y,
        output s_ready_x, f_wr_en, f_wr_addr, x_wr_en, x_wr_addr,
               f_rd_addr, x_rd_addr, mac_clr, mac_en, m_valid_y, conv_busy
`ifdef CONV_SEQ_PERF_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output s_valid_x, m_ready_y,
        input  s_ready_x, f_wr_en, f_wr_addr, x_wr_en, x_wr_addr,
               f_rd_addr, x_rd_addr, mac_clr, mac_en, m_valid_y, conv_busy
`ifdef CONV_SEQ_PERF_EN
        , input stall_cnt
`endif
    );

endinterface

// File: rtl/conv_seq_ctrl_load_addr_gen.sv
// conv_load_addr_gen: counts accepted load words and steers them into the
// F memory (first F_MEM_SIZE words) then the X memory (next X_MEM_SIZE).
//   clk, reset           : clock, synchronous active-high reset
//   wr_hs                : an input word is accepted this cycle
//   f_wr_en/f_wr_addr    : F memory write strobe/address (combinational)
//   x_wr_en/x_wr_addr    : X memory write strobe/address (combinational)
//   ld_last              : this handshake carries the final word of a vector
module conv_load_addr_gen #(
    parameter int unsigned X_MEM_SIZE       = 8,
    parameter int unsigned F_MEM_SIZE       = 4,
    parameter int unsigned X_MEM_ADDR_WIDTH = 3,
    parameter int unsigned F_MEM_ADDR_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_hs,
    output logic                        f_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr,
    output logic                        x_wr_en,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr,
    output logic                        ld_last
);
    localparam int unsigned LD_W = $clog2(X_MEM_SIZE + F_MEM_SIZE + 1);
    localparam logic [LD_W-1:0] F_CNT   = LD_W'(F_MEM_SIZE);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(F_MEM_SIZE + X_MEM_SIZE - 1);

    logic [LD_W-1:0] ld_cnt_q;
    logic            in_f;

    always_comb begin
        in_f      = (ld_cnt_q < F_CNT);
        f_wr_en   = wr_hs && in_f;
        x_wr_en   = wr_hs && !in_f;
        f_wr_addr = in_f ? ld_cnt_q[F_MEM_ADDR_WIDTH-1:0] : '0;
        x_wr_addr = in_f ? '0 : X_MEM_ADDR_WIDTH'(ld_cnt_q - F_CNT);
        ld_last   = wr_hs && (ld_cnt_q == LD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q <= '0;
        end else if (ld_last) begin
            ld_cnt_q <= '0;
        end else if (wr_hs) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: control sequencer for the convolution engine. Loads
// F_MEM_SIZE taps then X_MEM_SIZE samples, then for each of the
// X_MEM_SIZE-F_MEM_SIZE+1 output positions issues F/X read addresses,
// drives MAC clear/enable and presents the result with valid/ready.
//   clk, reset : clock, synchronous active-high reset
//   bus        : conv_seq_ctrl_if master modport (stream in, memory
//                write/read addressing, MAC controls, stream out, busy)
// Optional: CONV_SEQ_PERF_EN adds bus.stall_cnt, a saturating count of
// output backpressure cycles, cleared at the start of each vector.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned X_MEM_SIZE       = 8,
    parameter int unsigned F_MEM_SIZE       = 4,
    parameter int unsigned X_MEM_ADDR_WIDTH = 3,
    parameter int unsigned F_MEM_ADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    conv_seq_ctrl_if.master  bus
);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] K_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] P_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - F_MEM_SIZE);

    conv_state_t                 state_q, state_d;
    logic [F_MEM_ADDR_WIDTH-1:0] k_q;
    logic [X_MEM_ADDR_WIDTH-1:0] p_q;
    logic                        rd_vld_q;    // read data arrives the cycle after issue
    logic                        rd_first_q;  // that read was tap 0
    logic                        m_valid_q;
    logic                        in_hs;
    logic                        out_hs;
    logic                        ld_last;

    assign in_hs  = bus.s_valid_x && (state_q == LOAD);
    assign out_hs = m_valid_q && bus.m_ready_y;

    conv_load_addr_gen #(
        .X_MEM_SIZE       (X_MEM_SIZE),
        .F_MEM_SIZE       (F_MEM_SIZE),
        .X_MEM_ADDR_WIDTH (X_MEM_ADDR_WIDTH),
        .F_MEM_ADDR_WIDTH (F_MEM_ADDR_WIDTH)
    ) u_load_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .wr_hs     (in_hs),
        .f_wr_en   (bus.f_wr_en),
        .f_wr_addr (bus.f_wr_addr),
        .x_wr_en   (bus.x_wr_en),
        .x_wr_addr (bus.x_wr_addr),
        .ld_last   (ld_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_last) state_d = MAC;
            MAC:     if (k_q == K_LAST) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (out_hs) state_d = (p_q == P_LAST) ? LOAD : MAC;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            k_q        <= '0;
            p_q        <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_vld_q   <= (state_q == MAC);
            rd_first_q <= (state_q == MAC) && (k_q == '0);
            m_valid_q  <= (state_d == OUT);
            case (state_q)
                LOAD: begin
                    if (ld_last) begin
                        p_q <= '0;
                        k_q <= '0;
                    end
                end
                // k parks on the last tap so the read addresses stay put
                // through DRAIN and OUT.
                MAC: begin
                    if (k_q != K_LAST) k_q <= k_q + 1'b1;
                end
                OUT: begin
                    if (out_hs) begin
                        k_q <= '0;
                        p_q <= (p_q == P_LAST) ? '0 : p_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready_x = (state_q == LOAD);
    assign bus.conv_busy = (state_q != LOAD);
    assign bus.f_rd_addr = k_q;
    assign bus.x_rd_addr = p_q + X_MEM_ADDR_WIDTH'(k_q);
    assign bus.mac_en    = rd_vld_q;
    assign bus.mac_clr   = rd_first_q;
    assign bus.m_valid_y = m_valid_q;

`ifdef CONV_SEQ_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q == LOAD) && (state_d == MAC)) begin
            stall_cnt_q <= '0;
        end else if (m_valid_q && !bus.m_ready_y && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Top-level sequencer for the convolution engine.
- Accepts a stream of F_MEM_SIZE filter taps followed by X_MEM_SIZE input samples, and steers writes into the F and X memories.
- Then, for each output position, drives the read addresses and MAC clear/enable, and presents the result on an AXI-style valid/ready output.
- Owns only control. Data, memories and MAC live outside the block.

Parameters:
X_MEM_SIZE, 8, number of input samples per vector
F_MEM_SIZE, 4, number of filter taps (must be >= 1 and <= X_MEM_SIZE)
X_MEM_ADDR_WIDTH, 3, address width of X memory (clog2 of X_MEM_SIZE)
F_MEM_ADDR_WIDTH, 2, address width of F memory (clog2 of F_MEM_SIZE)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
s_valid_x  input  1  input word valid
s_ready_x  output  1  block can accept an input word
f_wr_en  output  1  write strobe, F memory
f_wr_addr  output  F_MEM_ADDR_WIDTH  F memory write address
x_wr_en  output  1  write strobe, X memory
x_wr_addr  output  X_MEM_ADDR_WIDTH  X memory write address
f_rd_addr  output  F_MEM_ADDR_WIDTH  F memory read address
x_rd_addr  output  X_MEM_ADDR_WIDTH  X memory read address
mac_clr  output  1  MAC loads product instead of accumulating
mac_en  output  1  MAC accumulate enable
m_valid_y  output  1  output result valid
m_ready_y  input  1  downstream accepts result
conv_busy  output  1  high in any state except LOAD

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. All state changes occur on the rising edge of clk.
- Reset values: state=LOAD, all counters 0, m_valid_y=0, mac_en=0, mac_clr=0.
  - Immediately after reset: s_ready_x=1 (combinational from state) and conv_busy=0.
- Reset mid-operation aborts everything; the next vector restarts with tap 0.
- States: LOAD, MAC, DRAIN, OUT.

LOAD:
- s_ready_x=1. A write occurs on each s_valid_x && s_ready_x; idle cycles are allowed.
- ld_cnt (width clog2(X+F+1)) counts accepted words.
- While ld_cnt<F: f_wr_en=1, f_wr_addr=ld_cnt. Otherwise: x_wr_en=1, x_wr_addr=ld_cnt-F.
- Write strobes are combinational: strobe = handshake.
- On the handshake with ld_cnt==F+X-1: go to MAC, clear ld_cnt, and set p=0, k=0.

MAC:
- s_ready_x=0. Each cycle: f_rd_addr=k, x_rd_addr=p+k, then k increments.
- When k==F-1 is issued: go to DRAIN.
- Memory read latency is 1 cycle, so rd_vld is registered and mac_en = rd_vld.
- mac_clr is high with the first mac_en of each position (tap 0).
- Timing, with MAC entered at cycle t:
  - addresses issued at t..t+F-1
  - mac_en high at t+1..t+F
  - mac_clr high at t+1 only
- DRAIN: one cycle. The final mac_en occurs here. Next state is OUT.

OUT:
- m_valid_y=1 (registered), first visible at t+F+1. It stays high until m_ready_y is seen high.
- m_valid_y must not drop without a handshake; the read addresses are held.
- On handshake:
  - if p==X-F: go to LOAD with m_valid_y=0 in the next cycle.
  - else: p increments, k=0, go to MAC.
- Output count per vector is X-F+1. With F==X there is a single output.
- Counter width: p and p+k fit in X_MEM_ADDR_WIDTH. No wrap-around occurs, because p+k <= X-1.
- s_valid_x outside LOAD is ignored (no handshake, no write).

Optional Feature:
CONV_SEQ_PERF_EN
- Defined: adds output stall_cnt [15:0]. It increments each cycle with m_valid_y && !m_ready_y, saturates at 16'hFFFF, and clears on reset and on entering MAC for p=0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} conv_state_t
  - localparam MEM_RD_LAT=1
  - the perf counter width constant 16
- One natural sub-module: conv_load_addr_gen (ld_cnt plus the F/X write steering).
- The FSM, tap/position counters and output handshake stay in the top module.

Test Plan:
1. Reset, then stream words 0..11 with s_valid_x held high (F=4, X=8):
   - f_wr_en on words 0-3 with addresses 0-3
   - x_wr_en on words 4-11 with addresses 0-7
   - conv_busy rises the cycle after word 11
2. First position, m_ready_y=1:
   - x_rd_addr 0,1,2,3 and f_rd_addr 0,1,2,3 on consecutive cycles
   - mac_en high for 4 cycles starting 1 cycle later; mac_clr on the first of these only
   - m_valid_y high 5 cycles after MAC entry
3. Backpressure: hold m_ready_y=0 for 10 cycles in OUT.
   - m_valid_y stays 1, no mac_en, s_ready_x=0
   - With CONV_SEQ_PERF_EN defined, stall_cnt=10
4. Full vector, m_ready_y=1:
   - exactly 5 handshakes, with x_rd_addr base 0..4
   - then LOAD with s_ready_x=1 and m_valid_y=0
   - a second vector produces identical sequences
5. Bubbly input: s_valid_x toggling every other cycle.
   - writes occur only on handshakes; addresses are contiguous with no skips
6. Assert reset during MAC for p=2.
   - next cycle: state LOAD, mac_en=0, m_valid_y=0
   - the next accepted word writes f_wr_addr=0
